// File: rtl/bin2bcd_seq.sv
//------------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential shift-add-3 (double-dabble) binary-to-BCD converter. It consumes
// one input bit per clock and feeds the 8-digit seven-segment scanner with a
// packed BCD word. The result register only changes on completion, so the
// display never shows partial conversions.
//
// Ports:
//   i_clk     system clock, all logic on the rising edge
//   i_rst_n   synchronous active-low reset
//   i_start   conversion request, sampled only while idle
//   i_bin     binary value, captured on the edge where i_start is accepted
//   o_busy    high while a conversion is in progress
//   o_done    one-cycle pulse: o_bcd/o_ovf were updated this cycle
//   o_bcd     packed BCD result, most significant digit in the top nibble
//   o_ovf     last input exceeded 10^DIGITS-1 (o_bcd then reads all nines)
//------------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int BIN_W  = 27,
   parameter int DIGITS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [BIN_W-1:0]      i_bin,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CMP_W = BIN_W + 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_FINISH = 2'd2;

   // 10^n evaluated at elaboration time; used only to build the range limit.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Every digit >= 5 gets +3 independently; no carry crosses digit borders.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
      logic [BCD_W-1:0] r;
      r = s;
      for (int d = 0; d < DIGITS; d++) begin
         if (s[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = s[4*d +: 4] + 4'd3;
         end else begin
            r[4*d +: 4] = s[4*d +: 4];
         end
      end
      return r;
   endfunction

   localparam logic [CMP_W-1:0] MAX_VAL  = CMP_W'(pow10(DIGITS) - 64'd1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);

   logic [1:0]        r_state;
   logic [BIN_W-1:0]  r_shift;
   logic [BCD_W-1:0]  r_scratch;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ovf_pend;
   logic              r_busy;
   logic              r_done;
   logic [BCD_W-1:0]  r_bcd;
   logic              r_ovf;

   logic [BCD_W-1:0]  w_adj;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_ovf_in;

   // Per-step datapath: digit correction, counter decrement, range compare.
   always_comb begin
      w_adj      = add3_digits(r_scratch);
      w_cnt_next = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      w_ovf_in   = ({4'b0000, i_bin} > MAX_VAL);
   end

   // Conversion FSM and result registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= {BIN_W{1'b0}};
         r_scratch  <= {BCD_W{1'b0}};
         r_cnt      <= {CNT_W{1'b0}};
         r_ovf_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= {BCD_W{1'b0}};
         r_ovf      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_shift    <= i_bin;
                  r_scratch  <= {BCD_W{1'b0}};
                  r_cnt      <= CNT_LOAD;
                  r_ovf_pend <= w_ovf_in;
                  r_busy     <= 1'b1;
                  r_state    <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_scratch <= {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
               r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
               r_cnt     <= w_cnt_next;
               // A bit pushed out of the top digit can only happen for
               // out-of-range inputs; fold it into the sticky flag as well.
               r_ovf_pend <= r_ovf_pend | w_adj[BCD_W-1];
               if (w_cnt_next == {CNT_W{1'b0}}) begin
                  r_state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               r_bcd   <= r_ovf_pend ? {DIGITS{4'h9}} : r_scratch;
               r_ovf   <= r_ovf_pend;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_bcd  = r_bcd;
   assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
//------------------------------------------------------------------------------
// tb_bin2bcd_seq
//
// Directed and swept self-checking bench for bin2bcd_seq. Inputs are driven
// 1ns after the rising edge and outputs are sampled at that same point.
//------------------------------------------------------------------------------
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [26:0] bin;
   logic        busy;
   logic        done;
   logic [31:0] bcd;
   logic        ovf;

   int n_tests;
   int n_fail;

   bin2bcd_seq #(.BIN_W(27), .DIGITS(8)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_bin   (bin),
      .o_busy  (busy),
      .o_done  (done),
      .o_bcd   (bcd),
      .o_ovf   (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Decimal reference: peel digits off with / and %.
   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = 32'h0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Issue a one-cycle start with the given value (accepted at this edge if idle).
   task automatic pulse_start(input logic [26:0] v);
      start = 1'b1;
      bin   = v;
      tick();
      start = 1'b0;
   endtask

   // Wait for done; cycles = -1 on timeout. busy_cnt counts busy samples
   // from the accepting edge up to (not including) the done sample.
   task automatic wait_done(output int cycles, output int busy_cnt);
      cycles   = -1;
      busy_cnt = busy ? 1 : 0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (done) begin
            cycles = c;
            return;
         end
         busy_cnt += busy ? 1 : 0;
      end
   endtask

   task automatic test_reset();
      start = 1'b0;
      bin   = 27'd0;
      rst_n = 1'b0;
      tick();
      tick();
      tick();
      n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_tests++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_tests++; if (bcd  !== 32'h0)  begin n_fail++; $display("FAIL reset_bcd got %h want 00000000", bcd); end
      n_tests++; if (ovf  !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int cyc, bc;
      pulse_start(27'd12345678);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", busy); end
      wait_done(cyc, bc);
      n_tests++; if (cyc !== 28) begin n_fail++; $display("FAIL basic_latency got %0d want 28", cyc); end
      n_tests++; if (bc !== 28) begin n_fail++; $display("FAIL basic_busy_len got %0d want 28", bc); end
      n_tests++; if (bcd !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_bcd got %h want 12345678", bcd); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall got %b want 0", busy); end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
      n_tests++; if (bcd !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_bcd_hold got %h want 12345678", bcd); end
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      pulse_start(27'd87654321);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h8765_4321) begin n_fail++; $display("FAIL b2b_first_bcd got %h want 87654321", bcd); end
      // start in the done cycle must be taken at the next edge
      pulse_start(27'd0);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got busy %b want 1", busy); end
      n_tests++; if (bcd !== 32'h8765_4321) begin n_fail++; $display("FAIL b2b_hold got %h want 87654321", bcd); end
      wait_done(cyc, bc);
      n_tests++; if (cyc !== 28) begin n_fail++; $display("FAIL b2b_latency got %0d want 28", cyc); end
      n_tests++; if (bcd !== 32'h0) begin n_fail++; $display("FAIL b2b_second_bcd got %h want 00000000", bcd); end
      tick();
   endtask

   task automatic test_overflow();
      int cyc, bc;
      pulse_start(27'd99999999);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h9999_9999) begin n_fail++; $display("FAIL ovf_max_bcd got %h want 99999999", bcd); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_max_flag got %b want 0", ovf); end
      tick();
      pulse_start(27'd100000000);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h9999_9999) begin n_fail++; $display("FAIL ovf_over_bcd got %h want 99999999", bcd); end
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_over_flag got %b want 1", ovf); end
      tick();
      pulse_start(27'h7FFFFFF);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h9999_9999) begin n_fail++; $display("FAIL ovf_top_bcd got %h want 99999999", bcd); end
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_top_flag got %b want 1", ovf); end
      tick();
      pulse_start(27'd5);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h0000_0005) begin n_fail++; $display("FAIL ovf_clear_bcd got %h want 00000005", bcd); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_flag got %b want 0", ovf); end
      tick();
   endtask

   task automatic test_ignore_busy();
      int ndone;
      ndone = 0;
      pulse_start(27'd42);
      for (int c = 1; c <= 70; c++) begin
         if (c == 10) begin
            start = 1'b1;
            bin   = 27'd77;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) ndone++;
      end
      start = 1'b0;
      n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", ndone); end
      n_tests++; if (bcd !== 32'h0000_0042) begin n_fail++; $display("FAIL ignore_bcd got %h want 00000042", bcd); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle got busy %b want 0", busy); end
   endtask

   task automatic test_reset_abort();
      int cyc, bc, ndone;
      pulse_start(27'd1234);
      wait_done(cyc, bc);
      n_tests++; if (bcd !== 32'h0000_1234) begin n_fail++; $display("FAIL abort_pre_bcd got %h want 00001234", bcd); end
      tick();
      ndone = 0;
      pulse_start(27'd999);
      for (int c = 2; c < 15; c++) begin
         tick();
         if (done) ndone++;
      end
      rst_n = 1'b0;
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_tests++; if (bcd !== 32'h0) begin n_fail++; $display("FAIL abort_bcd got %h want 00000000", bcd); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL abort_ovf got %b want 0", ovf); end
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) ndone++;
      end
      n_tests++; if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", ndone); end
      n_tests++; if (bcd !== 32'h0) begin n_fail++; $display("FAIL abort_bcd_after got %h want 00000000", bcd); end
   endtask

   task automatic test_sweep();
      int cyc, bc, accepts, dones, bad_nib;
      int unsigned v;
      logic [31:0] exp_bcd;
      accepts = 0;
      dones   = 0;
      for (int i = 0; i < 1000; i++) begin
         if (i == 0)      v = 0;
         else if (i == 1) v = 99999999;
         else if (i == 2) v = 9;
         else             v = $urandom_range(99999999, 0);
         exp_bcd = to_bcd(v);
         pulse_start(27'(v));
         if (busy) accepts++;
         wait_done(cyc, bc);
         if (cyc > 0) dones++;
         n_tests++;
         if (bcd !== exp_bcd || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_bcd in=%0d got %h ovf %b want %h ovf 0", v, bcd, ovf, exp_bcd);
         end
         bad_nib = 0;
         for (int d = 0; d < 8; d++) begin
            if (bcd[4*d +: 4] > 4'd9) bad_nib++;
         end
         n_tests++;
         if (bad_nib !== 0) begin
            n_fail++;
            $display("FAIL sweep_nibble in=%0d got %h want all digits 0..9", v, bcd);
         end
         tick();
      end
      n_tests++;
      if (dones !== accepts || accepts !== 1000) begin
         n_fail++;
         $display("FAIL sweep_done_count got dones %0d accepts %0d want 1000 each", dones, accepts);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      start   = 1'b0;
      bin     = 27'd0;
      rst_n   = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_ignore_busy();
      test_reset_abort();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
